tinynpu_core: RTL and testbench
===============================

// Module: tinynpu_core
// PURPOSE
//  Parametrised self-sequencing NPU tile: unified_buffer -> 2x streaming_skewer -> systolic_array plus an internal sequencer FSM.
//  Takes one matmul command (A/W base addresses, K depth, precision) over a valid/ready handshake and runs the whole tile.
//  Streams the NxN result back row by row over a valid/ready port. Successor to the fixed 4x4 top that needed an external controller.
// PARAMETERS
//  N            4     array rows/cols; skewer, buffer and array widths derive from it
//  DATA_WIDTH   16    operand lane width; buffer word = N*DATA_WIDTH
//  ACC_WIDTH    32    accumulator width per PE
//  ADDR_WIDTH   10    unified buffer address width
//  K_WIDTH      10    width of K (reduction depth) field; K range 1..2^K_WIDTH-1
//  FLUSH_TMO    64    max cycles in FLUSH waiting for all_done before error
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    synchronous reset, active-high
//  ub_wr_en     in   1                    host buffer write strobe
//  ub_wr_addr   in   ADDR_WIDTH           host write address
//  ub_wr_data   in   N*DATA_WIDTH         host write data, lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//  ub_wr_drop   out  1                    1-cycle pulse: write ignored (core busy)
//  cmd_valid    in   1                    command present
//  cmd_ready    out  1                    core can accept command (IDLE only)
//  cmd_a_base   in   ADDR_WIDTH           first input-row address
//  cmd_w_base   in   ADDR_WIDTH           first weight-row address
//  cmd_k        in   K_WIDTH              rows to stream (reduction depth)
//  cmd_prec     in   precision_mode_t     precision for systolic_array
//  res_valid    out  1                    result row present
//  res_ready    in   1                    consumer accepts row
//  res_data     out  N*ACC_WIDTH          row r: col c at [c*ACC_WIDTH +: ACC_WIDTH]
//  res_row      out  $clog2(N)            row index of res_data
//  res_last     out  1                    res_data is row N-1
//  busy         out  1                    state != IDLE
//  done         out  1                    1-cycle pulse on return to IDLE after a command
//  err          out  1                    valid with done: 1 = K==0 reject or flush timeout
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; FSM=IDLE; counters 0; submodules get rst_n = ~rst.
//  Command accepted on cmd_valid&&cmd_ready; fields latched that cycle; cmd_ready drops next cycle.
//  States: IDLE -> CLEAR -> STREAM -> FLUSH -> DRAIN -> OUTPUT -> IDLE.
//   IDLE: K==0 at accept -> stay IDLE, done=err=1 next cycle, no array activity.
//   CLEAR: exactly 1 cycle, acc_clear=1.
//   STREAM: K cycles, k=0..K-1: input_addr=a_base+k, weight_addr=w_base+k (wrap mod 2^ADDR_WIDTH);
//     first markers=1 at k==0, last markers=1 at k==K-1 (both at k=0 when K==1).
//     skewer_en=1 and compute_enable=1 from STREAM entry through FLUSH.
//   FLUSH: zero operands into buffer path; wait for systolic all_done -> DRAIN.
//     FLUSH_TMO cycles without all_done -> IDLE, done=err=1, no result rows emitted.
//   DRAIN: 1 cycle drain_enable=1; snapshot results[][] into result regs.
//   OUTPUT: row counter r=0..N-1; res_valid=1; res_data/res_row/res_last stable while res_valid&&!res_ready;
//     advance on res_valid&&res_ready; handshake on r==N-1 -> IDLE, done=1, err=0.
//  Buffer writes: honoured only in IDLE; in any other state dropped, ub_wr_drop=1 same cycle.
//  Write and command accept in same IDLE cycle: both honoured; write lands before first read (STREAM starts >=2 cycles later).
//  cmd_valid in non-IDLE states ignored (cmd_ready=0); no queueing.
//  Sync reset mid-operation: FSM to IDLE next edge, res_valid=0, no done pulse, snapshot cleared.
//  Address/counter arithmetic unsigned, truncated to ADDR_WIDTH / K_WIDTH; results signed ACC_WIDTH unchanged from array.
// TESTING
//  Identity W, A rows {1,2,3,4}.., K=4, INT16 -> rows out equal A, res_row 0..3, res_last on row 3, done=1 err=0.
//  cmd_k=0 -> no acc_clear/compute, done=err=1 one cycle after accept, cmd_ready back to 1.
//  res_ready held 0 for 10 cycles during OUTPUT -> res_data/res_row stable, no row skipped or repeated.
//  ub_wr_en pulse during STREAM -> ub_wr_drop=1, buffer contents unchanged (re-run gives identical results).
//  a_base=2^ADDR_WIDTH-2, K=4 -> reads wrap to 0,1; result matches golden model on wrapped data.
//  rst asserted during FLUSH -> next cycle busy=0, res_valid=0, cmd_ready=1; fresh command then completes correctly.

Source files
------------

// File: rtl/tinynpu_core.sv
// Self-sequencing NPU tile: unified buffer, two operand skewers and an output-stationary
// systolic array, run by one matmul command and drained row by row.
package tinynpu_pkg;
    typedef enum logic {PREC_INT16 = 1'b0, PREC_INT8 = 1'b1} precision_mode_t;
endpackage

// state  | meaning
// IDLE   | accept buffer writes and commands
// CLEAR  | zero accumulators, markers and done flags
// STREAM | read K operand rows, one per cycle
// FLUSH  | feed zeros until every PE has seen its last marker
// DRAIN  | snapshot accumulators into result registers
// OUTPUT | hand result rows to the consumer
module tinynpu_core
    import tinynpu_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int K_WIDTH    = 10,
    parameter int FLUSH_TMO  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ub_wr_en,
    input  logic [ADDR_WIDTH-1:0]     ub_wr_addr,
    input  logic [N*DATA_WIDTH-1:0]   ub_wr_data,
    output logic                      ub_wr_drop,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_a_base,
    input  logic [ADDR_WIDTH-1:0]     cmd_w_base,
    input  logic [K_WIDTH-1:0]        cmd_k,
    input  precision_mode_t           cmd_prec,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [N*ACC_WIDTH-1:0]    res_data,
    output logic [$clog2(N)-1:0]      res_row,
    output logic                      res_last,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int RW = $clog2(N);
    localparam int TW = $clog2(FLUSH_TMO + 1);
    localparam int BW = N * DATA_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_FLUSH, S_DRAIN, S_OUTPUT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] a_base, w_base;
    logic [K_WIDTH-1:0]    k_len, k_cnt;
    precision_mode_t       prec;
    logic [TW-1:0]         tmo_cnt;
    logic [RW-1:0]         row;

    logic acc_clear, compute_en, drain_en, all_done;

    assign acc_clear  = (state == S_CLEAR);
    assign compute_en = (state == S_STREAM) || (state == S_FLUSH);
    assign drain_en   = (state == S_DRAIN);

    logic [BW-1:0] mem [2**ADDR_WIDTH];
    logic [BW-1:0] rd_a, rd_w, op_a, op_w;
    logic          rd_v, rd_f, rd_l;

    always_ff @(posedge clk) begin
        if (ub_wr_en && state == S_IDLE) mem[ub_wr_addr] <= ub_wr_data;
        rd_a <= mem[a_base + ADDR_WIDTH'(k_cnt)];
        rd_w <= mem[w_base + ADDR_WIDTH'(k_cnt)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v <= 1'b0;
            rd_f <= 1'b0;
            rd_l <= 1'b0;
        end else begin
            rd_v <= (state == S_STREAM);
            rd_f <= (state == S_STREAM) && (k_cnt == '0);
            rd_l <= (state == S_STREAM) && (k_cnt == k_len - K_WIDTH'(1));
        end
    end

    // Outside valid stream slots the array sees zeros, never stale buffer words.
    assign op_a = rd_v ? rd_a : '0;
    assign op_w = rd_v ? rd_w : '0;

    logic [DATA_WIDTH-1:0] ska_sr [N][N];
    logic [DATA_WIDTH-1:0] skw_sr [N][N];
    logic                  skv_sr [N][N];
    logic                  skf_sr [N][N];
    logic                  skl_sr [N][N];
    logic [DATA_WIDTH-1:0] sk_a [N];
    logic [DATA_WIDTH-1:0] sk_w [N];
    logic                  sk_v [N];
    logic                  sk_f [N];
    logic                  sk_l [N];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < N; s++) begin
                if (rst || acc_clear) begin
                    ska_sr[i][s] <= '0;
                    skw_sr[i][s] <= '0;
                    skv_sr[i][s] <= 1'b0;
                    skf_sr[i][s] <= 1'b0;
                    skl_sr[i][s] <= 1'b0;
                end else if (compute_en) begin
                    if (s == 0) begin
                        ska_sr[i][s] <= op_a[i*DATA_WIDTH +: DATA_WIDTH];
                        skw_sr[i][s] <= op_w[i*DATA_WIDTH +: DATA_WIDTH];
                        skv_sr[i][s] <= rd_v;
                        skf_sr[i][s] <= rd_f;
                        skl_sr[i][s] <= rd_l;
                    end else begin
                        ska_sr[i][s] <= ska_sr[i][s-1];
                        skw_sr[i][s] <= skw_sr[i][s-1];
                        skv_sr[i][s] <= skv_sr[i][s-1];
                        skf_sr[i][s] <= skf_sr[i][s-1];
                        skl_sr[i][s] <= skl_sr[i][s-1];
                    end
                end
            end
        end
    end

    always_comb begin
        sk_a[0] = op_a[DATA_WIDTH-1:0];
        sk_w[0] = op_w[DATA_WIDTH-1:0];
        sk_v[0] = rd_v;
        sk_f[0] = rd_f;
        sk_l[0] = rd_l;
        for (int i = 1; i < N; i++) begin
            sk_a[i] = ska_sr[i][i-1];
            sk_w[i] = skw_sr[i][i-1];
            sk_v[i] = skv_sr[i][i-1];
            sk_f[i] = skf_sr[i][i-1];
            sk_l[i] = skl_sr[i][i-1];
        end
    end

    // INT8 mode multiplies the sign-extended low byte of each lane.
    function automatic logic signed [ACC_WIDTH-1:0] mul(input logic [DATA_WIDTH-1:0] a,
                                                        input logic [DATA_WIDTH-1:0] w,
                                                        input precision_mode_t p);
        logic signed [DATA_WIDTH-1:0]   av, wv;
        logic signed [2*DATA_WIDTH-1:0] pr;
        if (p == PREC_INT8) begin
            av = DATA_WIDTH'($signed(a[7:0]));
            wv = DATA_WIDTH'($signed(w[7:0]));
        end else begin
            av = $signed(a);
            wv = $signed(w);
        end
        pr = av * wv;
        return ACC_WIDTH'(pr);
    endfunction

    logic signed [ACC_WIDTH-1:0] acc [N][N];
    logic [DATA_WIDTH-1:0] a_reg [N][N], w_reg [N][N], a_in [N][N], w_in [N][N];
    logic v_reg [N][N], f_reg [N][N], l_reg [N][N], pe_done [N][N];
    logic v_in [N][N], f_in [N][N], l_in [N][N];

    // Operands and markers move right; weights move down.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = sk_a[i];
            v_in[i][0] = sk_v[i];
            f_in[i][0] = sk_f[i];
            l_in[i][0] = sk_l[i];
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = a_reg[i][j-1];
                v_in[i][j] = v_reg[i][j-1];
                f_in[i][j] = f_reg[i][j-1];
                l_in[i][j] = l_reg[i][j-1];
            end
        end
        for (int j = 0; j < N; j++) begin
            w_in[0][j] = sk_w[j];
            for (int i = 1; i < N; i++) w_in[i][j] = w_reg[i-1][j];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst || acc_clear) begin
                    acc[i][j]     <= '0;
                    a_reg[i][j]   <= '0;
                    w_reg[i][j]   <= '0;
                    v_reg[i][j]   <= 1'b0;
                    f_reg[i][j]   <= 1'b0;
                    l_reg[i][j]   <= 1'b0;
                    pe_done[i][j] <= 1'b0;
                end else if (compute_en) begin
                    a_reg[i][j] <= a_in[i][j];
                    w_reg[i][j] <= w_in[i][j];
                    v_reg[i][j] <= v_in[i][j];
                    f_reg[i][j] <= f_in[i][j];
                    l_reg[i][j] <= l_in[i][j];
                    if (v_in[i][j]) begin
                        acc[i][j] <= (f_in[i][j] ? '0 : acc[i][j]) + mul(a_in[i][j], w_in[i][j], prec);
                        if (l_in[i][j]) pe_done[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        all_done = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                all_done = all_done & pe_done[i][j];
    end

    logic [ACC_WIDTH-1:0] snap [N][N];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (rst) snap[i][j] <= '0;
                else if (drain_en) snap[i][j] <= acc[i][j];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_base  <= '0;
            w_base  <= '0;
            k_len   <= '0;
            k_cnt   <= '0;
            prec    <= PREC_INT16;
            tmo_cnt <= '0;
            row     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    a_base <= cmd_a_base;
                    w_base <= cmd_w_base;
                    k_len  <= cmd_k;
                    prec   <= cmd_prec;
                    k_cnt  <= '0;
                    if (cmd_k == '0) begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end else begin
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    k_cnt <= '0;
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (k_cnt == k_len - K_WIDTH'(1)) begin
                        tmo_cnt <= TW'(FLUSH_TMO - 1);
                        state   <= S_FLUSH;
                    end else begin
                        k_cnt <= k_cnt + K_WIDTH'(1);
                    end
                end
                S_FLUSH: begin
                    if (all_done) begin
                        state <= S_DRAIN;
                    end else if (tmo_cnt == '0) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                S_DRAIN: begin
                    row   <= '0;
                    state <= S_OUTPUT;
                end
                S_OUTPUT: if (res_ready) begin
                    if (row == RW'(N - 1)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        row <= row + RW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign res_valid  = (state == S_OUTPUT);
    assign res_row    = row;
    assign res_last   = res_valid && (row == RW'(N - 1));
    assign ub_wr_drop = ub_wr_en && (state != S_IDLE);

    always_comb begin
        res_data = '0;
        for (int c = 0; c < N; c++) res_data[c*ACC_WIDTH +: ACC_WIDTH] = snap[row][c];
    end
endmodule

// File: tb/tb_tinynpu_core.sv
// Randomised bench for tinynpu_core: a matrix-level model of the buffer and the matmul
// predicts every result row, and one compare process checks the result port each cycle.
module tb_tinynpu_core;
    import tinynpu_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ub_wr_en = 1'b0;
    logic [9:0]      ub_wr_addr = '0;
    logic [63:0]     ub_wr_data = '0;
    logic            ub_wr_drop;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [9:0]      cmd_a_base = '0;
    logic [9:0]      cmd_w_base = '0;
    logic [9:0]      cmd_k = '0;
    precision_mode_t cmd_prec = PREC_INT16;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [127:0]    res_data;
    logic [1:0]      res_row;
    logic            res_last;
    logic            busy, done, err;

    tinynpu_core dut (
        .clk(clk), .rst(rst),
        .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data), .ub_wr_drop(ub_wr_drop),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a_base(cmd_a_base), .cmd_w_base(cmd_w_base),
        .cmd_k(cmd_k), .cmd_prec(cmd_prec),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row),
        .res_last(res_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    logic [63:0]  mm [1024];
    logic [127:0] exp_rows [4];
    int           exp_idx = 0;
    bit           exp_active = 0;
    bit           stall_arm = 0;
    int           stall_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic longint opv(input logic [15:0] x, input bit int8);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = x[7:0];
        h = x;
        return int8 ? longint'(b) : longint'(h);
    endfunction

    // C[r][c] = sum over k of A[a+k] lane r times W[w+k] lane c, kept mod 2^32.
    task automatic compute_exp(input int a, input int w, input int k, input bit int8);
        for (int r = 0; r < 4; r++) begin
            exp_rows[r] = '0;
            for (int c = 0; c < 4; c++) begin
                longint s;
                logic [63:0] arow, wrow;
                s = 0;
                for (int kk = 0; kk < k; kk++) begin
                    arow = mm[(a + kk) % 1024];
                    wrow = mm[(w + kk) % 1024];
                    s += opv(arow[r*16 +: 16], int8) * opv(wrow[c*16 +: 16], int8);
                end
                exp_rows[r][c*32 +: 32] = s[31:0];
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            res_ready = 1'b0;
            stall_cnt--;
        end else if (stall_arm && res_valid) begin
            stall_arm = 0;
            stall_cnt = 9;
            res_ready = 1'b0;
        end else begin
            res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    logic [127:0] prev_data;
    logic [1:0]   prev_row;
    bit           prev_stall = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            chk("ready_vs_busy", 128'(cmd_ready), 128'(!busy));
            if (done) chk("done_while_busy", 128'(busy), 128'(0));
            if (res_valid) begin
                if (!exp_active || exp_idx >= 4) begin
                    chk("res_unexpected", 128'(res_valid), 128'(0));
                end else begin
                    chk("res_data", res_data, exp_rows[exp_idx]);
                    chk("res_row", 128'(res_row), 128'(exp_idx));
                    chk("res_last", 128'(res_last), 128'(exp_idx == 3));
                    if (res_ready) exp_idx++;
                end
                if (prev_stall) begin
                    chk("stall_data", res_data, prev_data);
                    chk("stall_row", 128'(res_row), 128'(prev_row));
                end
            end else begin
                chk("res_last_idle", 128'(res_last), 128'(0));
            end
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
            prev_row   = res_row;
        end
    end

    task automatic wr(input int addr, input logic [63:0] d);
        ub_wr_en   = 1'b1;
        ub_wr_addr = addr[9:0];
        ub_wr_data = d;
        @(negedge clk);
        chk("wr_drop_idle", 128'(ub_wr_drop), 128'(0));
        @(posedge clk);
        #1;
        ub_wr_en = 1'b0;
        mm[addr % 1024] = d;
    endtask

    task automatic issue(input int a, input int w, input int k, input bit int8);
        bit ok;
        cmd_a_base = a[9:0];
        cmd_w_base = w[9:0];
        cmd_k      = k[9:0];
        cmd_prec   = int8 ? PREC_INT8 : PREC_INT16;
        cmd_valid  = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        chk("cmd_accept", 128'(ok), 128'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run(input int a, input int w, input int k, input bit int8, input bit inject);
        bit got;
        compute_exp(a, w, k, int8);
        exp_idx    = 0;
        exp_active = 1;
        issue(a, w, k, int8);
        @(negedge clk);
        chk("busy_after_accept", 128'(busy), 128'(1));
        chk("ready_after_accept", 128'(cmd_ready), 128'(0));
        got = 0;
        for (int i = 1; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (inject && i == 2) begin
                ub_wr_en   = 1'b1;
                ub_wr_addr = a[9:0];
                ub_wr_data = ~mm[a % 1024];
            end else begin
                ub_wr_en = 1'b0;
            end
            @(negedge clk);
            if (inject && i == 2) chk("wr_drop_busy", 128'(ub_wr_drop), 128'(1));
            if (done) begin
                got = 1;
                break;
            end
        end
        ub_wr_en = 1'b0;
        chk("done_seen", 128'(got), 128'(1));
        chk("err_on_success", 128'(err), 128'(0));
        chk("rows_out", 128'(exp_idx), 128'(4));
        exp_active = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mm[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_res_valid", 128'(res_valid), 128'(0));
        chk("rst_res_data", res_data, 128'(0));
        chk("rst_res_row", 128'(res_row), 128'(0));
        chk("rst_wr_drop", 128'(ub_wr_drop), 128'(0));
        @(posedge clk);
        #1;

        // Identity weights: C[r][c] = A[c] lane r, the transpose of the stored rows.
        for (int k = 0; k < 4; k++) begin
            wr(k, {16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)});
            wr(16 + k, 64'(1) << (16*k));
        end
        compute_exp(0, 16, 4, 0);
        chk("model_identity_row0", exp_rows[0], {32'd13, 32'd9, 32'd5, 32'd1});
        run(0, 16, 4, 0, 0);

        stall_arm = 1;
        run(0, 16, 4, 0, 0);

        issue(0, 16, 0, 0);
        @(negedge clk);
        chk("k0_done", 128'(done), 128'(1));
        chk("k0_err", 128'(err), 128'(1));
        chk("k0_busy", 128'(busy), 128'(0));
        chk("k0_ready", 128'(cmd_ready), 128'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("k0_done_pulse", 128'(done), 128'(0));
        @(posedge clk);
        #1;

        run(0, 16, 4, 0, 1);
        run(0, 16, 4, 0, 0);

        for (int k = 0; k < 4; k++) begin
            wr((1022 + k) % 1024, {4{16'(k+1)}});
            wr(100 + k, {4{16'd3}});
        end
        compute_exp(1022, 100, 4, 0);
        chk("model_wrap_row2", exp_rows[2], {4{32'd30}});
        run(1022, 100, 4, 0, 0);

        wr(200, {4{16'h12FE}});
        wr(201, {4{16'h0003}});
        compute_exp(200, 201, 1, 1);
        chk("model_int8_row1", exp_rows[1], {4{32'hFFFFFFFA}});
        run(200, 201, 1, 1, 0);

        // Reset lands while the array is still flushing.
        exp_active = 0;
        issue(0, 16, 4, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_busy", 128'(busy), 128'(0));
        chk("rst_flush_res_valid", 128'(res_valid), 128'(0));
        chk("rst_flush_ready", 128'(cmd_ready), 128'(1));
        chk("rst_flush_done", 128'(done), 128'(0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_flush_quiet", 128'({done, res_valid}), 128'(0));
        end
        @(posedge clk);
        #1;
        run(0, 16, 4, 0, 0);

        for (int t = 0; t < 8; t++) begin
            int a, w, k;
            bit int8;
            k    = $urandom_range(1, 20);
            a    = $urandom_range(0, 1023);
            w    = $urandom_range(0, 1023);
            int8 = ($urandom_range(0, 1) == 1);
            for (int kk = 0; kk < k; kk++) wr((a + kk) % 1024, {$urandom, $urandom});
            for (int kk = 0; kk < k; kk++) wr((w + kk) % 1024, {$urandom, $urandom});
            run(a, w, k, int8, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
